// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor
//   Measures the frequency of a divided PLL output (meas_tgl) against the
//   reference clock clkin and derives a "locked" flag from the measurement.
//   Rising edges of meas_tgl are counted over a gate of GATE_CYCLES clkin
//   cycles. Each completed window publishes its count and range flags.
//   locked asserts after LOCK_WINDOWS consecutive in-range windows and drops
//   on the first out-of-range window, on abort (enable low mid-window) or on
//   reset.
//
// Ports
//   clkin       : reference clock
//   reset       : synchronous, active-high
//   enable      : run measurements while high
//   meas_tgl    : asynchronous measured square wave, f < f(clkin)/4
//   locked      : frequency stable and in range
//   freq_count  : edge count of the last completed window
//   count_valid : one-cycle pulse when freq_count updates
//   too_slow    : last window count was below EXP_MIN
//   too_fast    : last window count was above EXP_MAX
module pll_lock_monitor #(
  parameter int GATE_CYCLES  = 24000,
  parameter int CNT_WIDTH    = 16,
  parameter int EXP_MIN      = 1560,
  parameter int EXP_MAX      = 1590,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic                 clkin,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 meas_tgl,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] freq_count,
  output logic                 count_valid,
  output logic                 too_slow,
  output logic                 too_fast
);

  localparam int                   GATE_W    = $clog2(GATE_CYCLES + 1);
  localparam logic [GATE_W-1:0]    GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] EXP_MIN_C = CNT_WIDTH'(EXP_MIN);
  localparam logic [CNT_WIDTH-1:0] EXP_MAX_C = CNT_WIDTH'(EXP_MAX);
  localparam logic [3:0]           LOCK_N    = 4'(LOCK_WINDOWS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    EVAL    = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   s1;
  logic                   s2;
  logic                   s3;
  logic                   rise;
  logic [GATE_W-1:0]      gate_cnt;
  logic [CNT_WIDTH-1:0]   edge_cnt;
  logic [3:0]             streak;
  logic [3:0]             streak_nxt;
  logic                   cnt_slow;
  logic                   cnt_fast;

  // Edge counter saturates instead of wrapping so an overspeed input can
  // never alias back into the valid range.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Good-window streak stops climbing at LOCK_WINDOWS.
  function automatic logic [3:0] streak_inc(input logic [3:0] s);
    return (s >= LOCK_N) ? LOCK_N : s + 4'd1;
  endfunction

  assign rise = s2 & ~s3;

  always_comb begin
    state_nxt  = state;
    cnt_slow   = (edge_cnt < EXP_MIN_C);
    cnt_fast   = (edge_cnt > EXP_MAX_C);
    streak_nxt = streak_inc(streak);
    case (state)
      IDLE: begin
        if (enable) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (!enable)                    state_nxt = IDLE;
        else if (gate_cnt == GATE_LAST) state_nxt = EVAL;
      end
      EVAL: begin
        state_nxt = enable ? MEASURE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state       <= IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      streak      <= 4'd0;
      locked      <= 1'b0;
      freq_count  <= '0;
      count_valid <= 1'b0;
      too_slow    <= 1'b0;
      too_fast    <= 1'b0;
    end else begin
      state       <= state_nxt;
      // 2-FF synchronizer (s1, s2) plus one history flop for edge detect
      s1          <= meas_tgl;
      s2          <= s1;
      s3          <= s2;
      count_valid <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
        end
        MEASURE: begin
          if (!enable) begin
            // Abort: discard the partial window, published results stay.
            gate_cnt <= '0;
            edge_cnt <= '0;
            streak   <= 4'd0;
            locked   <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            if (rise) edge_cnt <= sat_inc(edge_cnt);
          end
        end
        EVAL: begin
          // Single dead cycle: a rise seen here is dropped on purpose.
          freq_count  <= edge_cnt;
          count_valid <= 1'b1;
          too_slow    <= cnt_slow;
          too_fast    <= cnt_fast;
          if (!cnt_slow && !cnt_fast) begin
            streak <= streak_nxt;
            if (streak_nxt == LOCK_N) locked <= 1'b1;
          end else begin
            streak <= 4'd0;
            locked <= 1'b0;
          end
          gate_cnt <= '0;
          edge_cnt <= '0;
        end
        default: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor (GATE_CYCLES=100, EXP 9..11,
// LOCK_WINDOWS=3, CNT_WIDTH=8) plus a GATE_CYCLES=2000 instance for
// counter saturation. Inputs change on the falling edge; the periodic
// meas_tgl generator updates 2 ns after each rising edge.
module tb_pll_lock_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       meas_tgl;
  logic       locked;
  logic [7:0] freq_count;
  logic       count_valid;
  logic       too_slow;
  logic       too_fast;

  logic       sat_rst;
  logic       sat_en;
  logic       sat_locked;
  logic [7:0] sat_freq;
  logic       sat_cv;
  logic       sat_ts;
  logic       sat_tf;

  logic       gen_on;
  logic       gen_meas = 1'b0;
  logic       man_meas;
  int         req_per = 0;
  int         cur_per = 0;
  int         ph = 0;

  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  assign meas_tgl = gen_on ? gen_meas : man_meas;

  pll_lock_monitor #(
    .GATE_CYCLES(100), .CNT_WIDTH(8), .EXP_MIN(9), .EXP_MAX(11), .LOCK_WINDOWS(3)
  ) dut (
    .clkin(clk), .reset(rst), .enable(en), .meas_tgl(meas_tgl),
    .locked(locked), .freq_count(freq_count), .count_valid(count_valid),
    .too_slow(too_slow), .too_fast(too_fast)
  );

  pll_lock_monitor #(
    .GATE_CYCLES(2000), .CNT_WIDTH(8), .EXP_MIN(9), .EXP_MAX(11), .LOCK_WINDOWS(3)
  ) dut_sat (
    .clkin(clk), .reset(sat_rst), .enable(sat_en), .meas_tgl(meas_tgl),
    .locked(sat_locked), .freq_count(sat_freq), .count_valid(sat_cv),
    .too_slow(sat_ts), .too_fast(sat_tf)
  );

  // Square wave of period cur_per clkin cycles, high for the first half.
  // A period change restarts the phase at the high half.
  always @(posedge clk) begin
    #2;
    if (req_per != cur_per) begin
      cur_per = req_per;
      ph      = 0;
    end
    if (cur_per != 0) begin
      gen_meas = (ph < cur_per / 2);
      ph       = (ph + 1 >= cur_per) ? 0 : ph + 1;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int in_rng(input int v, input int lo, input int hi);
    return (v >= lo && v <= hi) ? 1 : 0;
  endfunction

  // Steps falling edges until count_valid is seen; n = edges waited.
  task automatic wait_cv(input string tag, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (count_valid !== 1'b1 && n < limit);
    check_eq({tag, "_arrived"}, int'(count_valid), 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_locked"}, int'(locked), 0);
    check_eq({tag, "_freq"}, int'(freq_count), 0);
    check_eq({tag, "_cv"}, int'(count_valid), 0);
    check_eq({tag, "_slow"}, int'(too_slow), 0);
    check_eq({tag, "_fast"}, int'(too_fast), 0);
  endtask

  // Manual meas_tgl for the boundary run; s counts falling edges after
  // enable is raised. A level driven at step s is counted on rising edge
  // s+2, and window w (1-based) counts rising edges 101(w-1)+1 .. +100.
  function automatic logic meas_at(input int s);
    int n_pulses[4] = '{9, 11, 10, 12};
    if (s == 98) return 1'b1;               // detected on last MEASURE cycle
    if (s >= 200 && s <= 205) return 1'b1;  // detected during EVAL of window 2
    for (int w = 0; w < 4; w++) begin
      int off;
      off = s - (101 * (w + 2) + 10);
      if (off >= 0 && off < 4 * n_pulses[w] && (off % 4) < 2) return 1'b1;
    end
    return 1'b0;
  endfunction

  int n;
  int fc_hold;
  int cv_seen;
  int ncv;
  int cv_at[8];
  int cv_fc[8];
  int cv_ts[8];
  int cv_tf[8];
  int cv_lk[8];
  int exp_fc[6] = '{1, 0, 9, 11, 10, 12};
  int exp_ts[6] = '{1, 1, 0, 0, 0, 0};
  int exp_tf[6] = '{0, 0, 0, 0, 0, 1};
  int exp_lk[6] = '{0, 0, 0, 0, 1, 0};

  initial begin
    rst = 1'b1; en = 1'b0; sat_rst = 1'b1; sat_en = 1'b0;
    gen_on = 1'b1; man_meas = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");

    // Nominal lock, period 10 -> 10 edges per window
    rst = 1'b0; en = 1'b1; req_per = 10;
    wait_cv("nom_w1", 300, n);
    check_eq("nom_w1_latency", n, 102);
    check_eq("nom_w1_cnt_9to11", in_rng(freq_count, 9, 11), 1);
    check_eq("nom_w1_slow", int'(too_slow), 0);
    check_eq("nom_w1_fast", int'(too_fast), 0);
    check_eq("nom_w1_locked", int'(locked), 0);
    wait_cv("nom_w2", 300, n);
    check_eq("nom_w2_period", n, 101);
    check_eq("nom_w2_cnt_9to11", in_rng(freq_count, 9, 11), 1);
    check_eq("nom_w2_locked", int'(locked), 0);
    wait_cv("nom_w3", 300, n);
    check_eq("nom_w3_period", n, 101);
    check_eq("nom_w3_locked", int'(locked), 1);

    // Loss of lock, period 20 -> 4 edges in the next window
    req_per = 20;
    wait_cv("slow_w", 300, n);
    check_eq("slow_cnt_4to6", in_rng(freq_count, 4, 6), 1);
    check_eq("slow_flag", int'(too_slow), 1);
    check_eq("slow_fast_flag", int'(too_fast), 0);
    check_eq("slow_locked", int'(locked), 0);
    req_per = 10;
    wait_cv("relock_w1", 300, n);
    check_eq("relock_w1_locked", int'(locked), 0);
    check_eq("relock_w1_cnt_9to11", in_rng(freq_count, 9, 11), 1);
    wait_cv("relock_w2", 300, n);
    check_eq("relock_w2_locked", int'(locked), 0);
    wait_cv("relock_w3", 300, n);
    check_eq("relock_w3_locked", int'(locked), 1);

    // Too fast, period 4 -> 25 edges
    req_per = 4;
    wait_cv("fast_w1", 300, n);
    check_eq("fast_w1_flag", int'(too_fast), 1);
    check_eq("fast_w1_locked", int'(locked), 0);
    wait_cv("fast_w2", 300, n);
    check_eq("fast_w2_cnt_24to26", in_rng(freq_count, 24, 26), 1);
    check_eq("fast_w2_flag", int'(too_fast), 1);
    check_eq("fast_w2_slow", int'(too_slow), 0);
    check_eq("fast_w2_locked", int'(locked), 0);

    // Saturation: 500 edges in a 2000-cycle gate must read 255
    sat_rst = 1'b0; sat_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sat_cv !== 1'b1 && n < 2200);
    check_eq("sat_arrived", int'(sat_cv), 1);
    check_eq("sat_latency", n, 2002);
    check_eq("sat_cnt", int'(sat_freq), 255);
    check_eq("sat_fast", int'(sat_tf), 1);
    check_eq("sat_slow", int'(sat_ts), 0);
    check_eq("sat_locked", int'(sat_locked), 0);

    // Abort at the start of a window: published results are held
    wait_cv("abort_sync", 300, n);
    fc_hold = int'(freq_count);
    en = 1'b0; sat_en = 1'b0; req_per = 10;
    @(negedge clk);
    check_eq("abort0_freq_held", int'(freq_count), fc_hold);
    check_eq("abort0_fast_held", int'(too_fast), 1);
    check_eq("abort0_locked", int'(locked), 0);
    repeat (20) @(negedge clk);
    en = 1'b1;
    wait_cv("ab_w1", 300, n);
    check_eq("ab_w1_latency", n, 102);
    check_eq("ab_w1_locked", int'(locked), 0);
    wait_cv("ab_w2", 300, n);
    check_eq("ab_w2_locked", int'(locked), 0);
    wait_cv("ab_w3", 300, n);
    check_eq("ab_w3_locked", int'(locked), 1);

    // Abort while locked, 50 cycles into the window
    fc_hold = int'(freq_count);
    repeat (50) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_eq("abort1_locked", int'(locked), 0);
    check_eq("abort1_freq_held", int'(freq_count), fc_hold);
    check_eq("abort1_slow_held", int'(too_slow), 0);
    cv_seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (count_valid) cv_seen++;
    end
    check_eq("abort1_no_cv", cv_seen, 0);

    // Abort with streak=1, then three fresh windows are needed
    en = 1'b1;
    wait_cv("st_w1", 300, n);
    check_eq("st_w1_locked", int'(locked), 0);
    repeat (50) @(negedge clk);
    en = 1'b0;
    repeat (30) @(negedge clk);
    en = 1'b1;
    wait_cv("st_r1", 300, n);
    check_eq("st_r1_latency", n, 102);
    check_eq("st_r1_locked", int'(locked), 0);
    wait_cv("st_r2", 300, n);
    check_eq("st_r2_locked", int'(locked), 0);
    wait_cv("st_r3", 300, n);
    check_eq("st_r3_locked", int'(locked), 1);

    // Reset at cycle 70 of a window
    repeat (70) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrst");
    rst = 1'b0;
    wait_cv("midrst_w1", 300, n);
    check_eq("midrst_latency", n, 102);
    check_eq("midrst_locked", int'(locked), 0);
    check_eq("midrst_cnt_9to11", in_rng(freq_count, 9, 11), 1);

    // Boundary run with hand-placed edges
    rst = 1'b1; en = 1'b0; gen_on = 1'b0; man_meas = 1'b0; req_per = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0; en = 1'b1;
    ncv = 0;
    for (int s = 1; s <= 615; s++) begin
      @(negedge clk);
      if (count_valid && ncv < 8) begin
        cv_at[ncv] = s;
        cv_fc[ncv] = int'(freq_count);
        cv_ts[ncv] = int'(too_slow);
        cv_tf[ncv] = int'(too_fast);
        cv_lk[ncv] = int'(locked);
        ncv++;
      end
      man_meas = meas_at(s);
    end
    check_eq("bnd_windows", ncv, 6);
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("bnd_w%0d_step", k + 1), cv_at[k], 101 * (k + 1) + 1);
      check_eq($sformatf("bnd_w%0d_cnt", k + 1), cv_fc[k], exp_fc[k]);
      check_eq($sformatf("bnd_w%0d_slow", k + 1), cv_ts[k], exp_ts[k]);
      check_eq($sformatf("bnd_w%0d_fast", k + 1), cv_tf[k], exp_tf[k]);
      check_eq($sformatf("bnd_w%0d_locked", k + 1), cv_lk[k], exp_lk[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
